// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel, EX redirect,
// and the valid/ready hand-off to decode. master = fetch unit, slave = environment.
interface ifu_fetch_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = 32
);
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i;
  logic              imem_rvalid_i;
  logic [INST_W-1:0] imem_rdata_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              inst_valid_o;
  logic              inst_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem fetch FSM and a small fetch FIFO.
// Optional performance counters are enabled with the IFU_PERF_CNT_EN macro.
module ifu_fetch #(
  parameter int unsigned       ADDR_W   = 64,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned       FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef IFU_PERF_CNT_EN
  output logic [63:0] ifu_fetch_cnt_o,
  output logic [63:0] ifu_stall_cnt_o,
`endif
  ifu_fetch_if.master bus
);

  localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DepthC = CNT_W'(FQ_DEPTH);

  typedef enum logic [1:0] {StHold, StReq, StWait, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_upd;
  logic              push, pop, head_valid;

  logic [INST_W-1:0] inst_mem [FQ_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FQ_DEPTH];

  assign head_valid = (cnt_q != '0);
  // A redirect clears the FIFO, so neither a push nor a pop may take effect that cycle.
  assign pop     = head_valid && bus.inst_ready_i && !bus.redirect_i;
  assign push    = (state_q == StWait) && bus.imem_rvalid_i && !bus.redirect_i;
  assign cnt_upd = cnt_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_upd;
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case (state_q)
      StHold:  if (cnt_q < DepthC) state_d = StReq;
      StReq: begin
        if (bus.imem_gnt_i) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + ADDR_W'(4);
          state_d  = StWait;
        end
      end
      StWait:  if (bus.imem_rvalid_i) state_d = (cnt_upd < DepthC) ? StReq : StHold;
      StFlush: if (bus.imem_rvalid_i) state_d = StReq;
      default: state_d = StHold;
    endcase

    if (bus.redirect_i) begin
      pc_d     = bus.redirect_pc_i;
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // A granted-but-unanswered request becomes stale and must be drained in FLUSH.
      unique case (state_q)
        StHold:  state_d = StReq;
        StReq:   state_d = bus.imem_gnt_i    ? StFlush : StReq;
        StWait:  state_d = bus.imem_rvalid_i ? StReq   : StFlush;
        StFlush: state_d = bus.imem_rvalid_i ? StReq   : StFlush;
        default: state_d = StHold;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StHold;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr_q] <= bus.imem_rdata_i;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

  assign bus.imem_req_o   = (state_q == StReq);
  assign bus.imem_addr_o  = pc_q;
  assign bus.inst_valid_o = head_valid;
  assign bus.inst_o       = head_valid ? inst_mem[rd_ptr_q] : '0;
  assign bus.pc_o         = head_valid ? pc_mem[rd_ptr_q]   : '0;

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) fetch_cnt_q <= fetch_cnt_q + 64'd1;
      if (head_valid && !bus.inst_ready_i) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign ifu_fetch_cnt_o = fetch_cnt_q;
  assign ifu_stall_cnt_o = stall_cnt_q;
`endif

endmodule
